filter_stream_sequencer: RTL and testbench

//  Write-port sequencer between the N parallel pixel filters and the single frame-buffer write port.

---
 rtl/filter_stream_sequencer.sv | 125 ++++++++++++
 tb/tb_filter_stream_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_stream_sequencer.sv
// Forwards exactly one filter's frame-buffer write stream. Source changes are committed at the
// new source's own frame start (addr 0), with a timeout fallback if that frame start never arrives.
module filter_stream_sequencer #(
    parameter int NUM_SRC      = 4,
    parameter int IMG_WIDTH    = 320,
    parameter int IMG_HEIGHT   = 240,
    parameter int DEFAULT_MODE = 0,
    parameter int TIMEOUT_CYC  = 2000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mode_req,
    input  logic [$clog2(NUM_SRC)-1:0] mode_sel,
    input  logic [NUM_SRC-1:0]         src_we,
    input  logic [NUM_SRC*17-1:0]      src_addr,
    input  logic [NUM_SRC*16-1:0]      src_data,
    output logic                       we_out,
    output logic [16:0]                wAddr_out,
    output logic [15:0]                wData_out,
    output logic [$clog2(NUM_SRC)-1:0] active_mode,
    output logic                       switch_pending,
    output logic                       frame_done,
    output logic                       switch_timeout
);

    localparam int          MW        = $clog2(NUM_SRC);
    localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] LAST_ADDR = 17'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {RUN, PENDING} state_t;

    state_t          state, state_nxt;
    logic [MW-1:0]   active_nxt;
    logic [MW-1:0]   target, target_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            timeout_nxt;
    logic [MW-1:0]   sel_p0;
    logic            req_valid;
    logic            commit;
    logic [16:0]     addr_arr [NUM_SRC];
    logic [15:0]     data_arr [NUM_SRC];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            addr_arr[i] = src_addr[17*i +: 17];
            data_arr[i] = src_data[16*i +: 16];
        end
    end

    assign req_valid      = mode_req && (32'(mode_sel) < NUM_SRC);
    assign commit         = (state == PENDING) && src_we[target] && (addr_arr[target] == 17'd0);
    assign switch_pending = (state == PENDING);

    // Commit takes priority over any request; a request beats the timeout.
    always_comb begin
        state_nxt   = state;
        active_nxt  = active_mode;
        target_nxt  = target;
        timer_nxt   = timer;
        timeout_nxt = 1'b0;
        sel_p0      = active_mode;
        case (state)
            RUN: begin
                timer_nxt = '0;
                if (req_valid && (mode_sel != active_mode)) begin
                    target_nxt = mode_sel;
                    state_nxt  = PENDING;
                end
            end
            PENDING: begin
                timer_nxt = timer + TW'(1);
                if (commit) begin
                    sel_p0     = target;
                    active_nxt = target;
                    state_nxt  = RUN;
                end else if (req_valid && (mode_sel == active_mode)) begin
                    state_nxt = RUN;
                end else if (req_valid && (mode_sel != target)) begin
                    target_nxt = mode_sel;
                    timer_nxt  = '0;
                end else if (timer == TIMER_END) begin
                    active_nxt  = target;
                    timeout_nxt = 1'b1;
                    state_nxt   = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            active_mode <= MW'(DEFAULT_MODE);
            target      <= MW'(DEFAULT_MODE);
            timer       <= '0;
        end else begin
            state       <= state_nxt;
            active_mode <= active_nxt;
            target      <= target_nxt;
            timer       <= timer_nxt;
        end
    end

    // Output register stage: one cycle from the selected source to the frame buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_out         <= 1'b0;
            wAddr_out      <= '0;
            wData_out      <= '0;
            frame_done     <= 1'b0;
            switch_timeout <= 1'b0;
        end else begin
            we_out         <= src_we[sel_p0];
            frame_done     <= src_we[sel_p0] && (addr_arr[sel_p0] == LAST_ADDR);
            switch_timeout <= timeout_nxt;
            if (src_we[sel_p0]) begin
                wAddr_out <= addr_arr[sel_p0];
                wData_out <= data_arr[sel_p0];
            end
        end
    end

endmodule

// File: tb/tb_filter_stream_sequencer.sv
// Directed bench for filter_stream_sequencer: reset, full-frame passthrough, table-driven
// switch/collision/cancel/invalid-request vectors, timeout and mid-switch reset.
module tb_filter_stream_sequencer;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode_req;
    logic [1:0]    mode_sel;
    logic [NS-1:0] src_we;
    logic [NS*17-1:0] src_addr;
    logic [NS*16-1:0] src_data;
    logic          we_out;
    logic [16:0]   wAddr_out;
    logic [15:0]   wData_out;
    logic [1:0]    active_mode;
    logic          switch_pending;
    logic          frame_done;
    logic          switch_timeout;

    int total = 0;
    int bad   = 0;

    filter_stream_sequencer #(
        .NUM_SRC(NS), .IMG_WIDTH(320), .IMG_HEIGHT(240), .DEFAULT_MODE(0), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset(reset), .mode_req(mode_req), .mode_sel(mode_sel),
        .src_we(src_we), .src_addr(src_addr), .src_data(src_data),
        .we_out(we_out), .wAddr_out(wAddr_out), .wData_out(wData_out),
        .active_mode(active_mode), .switch_pending(switch_pending),
        .frame_done(frame_done), .switch_timeout(switch_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [1:0]  sel;
        logic        we0;
        logic [16:0] a0;
        logic        we1;
        logic [16:0] a1;
        logic        ewe;
        logic [16:0] eaddr;
        logic [1:0]  esrc;
        logic        epend;
        logic [1:0]  eact;
        logic        efd;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic drive(input int i, input logic we, input logic [16:0] a, input logic [15:0] d);
        src_we[i]          = we;
        src_addr[17*i +: 17] = a;
        src_data[16*i +: 16] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] tdat(input logic [1:0] s, input logic [16:0] a);
        return {s, 2'b00, a[11:0]};
    endfunction

    initial begin
        int errs;
        int fd_cnt;
        int fd_at;

        //            req  sel   we0  a0        we1  a1        ewe  eaddr     esrc pend act  fd
        tbl[0]  = '{1'b1, 2'd3, 1'b1, 17'd10,    1'b1, 17'd20,    1'b1, 17'd10,    2'd0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 1'b1, 17'd11,    1'b1, 17'd21,    1'b1, 17'd11,    2'd0, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'd1, 1'b1, 17'd76797, 1'b1, 17'd76794, 1'b1, 17'd76797, 2'd0, 1'b1, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 17'd76798, 1'b1, 17'd76795, 1'b1, 17'd76798, 2'd0, 1'b1, 2'd0, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 17'd76799, 1'b1, 17'd76796, 1'b1, 17'd76799, 2'd0, 1'b1, 2'd0, 1'b1};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 17'd0,     1'b1, 17'd76797, 1'b1, 17'd0,     2'd0, 1'b1, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 17'd1,     1'b1, 17'd76798, 1'b1, 17'd1,     2'd0, 1'b1, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 17'd2,     1'b1, 17'd76799, 1'b1, 17'd2,     2'd0, 1'b1, 2'd0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 17'd3,     1'b1, 17'd0,     1'b1, 17'd0,     2'd1, 1'b0, 2'd1, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 17'd4,     1'b1, 17'd1,     1'b1, 17'd1,     2'd1, 1'b0, 2'd1, 1'b0};
        tbl[10] = '{1'b1, 2'd0, 1'b1, 17'd5,     1'b1, 17'd2,     1'b1, 17'd2,     2'd1, 1'b1, 2'd1, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b1, 17'd0,     1'b1, 17'd3,     1'b1, 17'd0,     2'd0, 1'b0, 2'd0, 1'b0};
        tbl[12] = '{1'b1, 2'd1, 1'b1, 17'd1,     1'b1, 17'd4,     1'b1, 17'd1,     2'd0, 1'b1, 2'd0, 1'b0};
        tbl[13] = '{1'b1, 2'd0, 1'b1, 17'd2,     1'b1, 17'd5,     1'b1, 17'd2,     2'd0, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{1'b1, 2'd1, 1'b1, 17'd76798, 1'b1, 17'd76799, 1'b1, 17'd76798, 2'd0, 1'b1, 2'd0, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 1'b1, 17'd76799, 1'b1, 17'd0,     1'b1, 17'd0,     2'd1, 1'b0, 2'd1, 1'b0};
        tbl[16] = '{1'b0, 2'd0, 1'b1, 17'd0,     1'b1, 17'd1,     1'b1, 17'd1,     2'd1, 1'b0, 2'd1, 1'b0};
        tbl[17] = '{1'b0, 2'd0, 1'b1, 17'd1,     1'b0, 17'd9,     1'b0, 17'd1,     2'd1, 1'b0, 2'd1, 1'b0};
        tbl[18] = '{1'b0, 2'd0, 1'b1, 17'd2,     1'b1, 17'd76800, 1'b1, 17'd76800, 2'd1, 1'b0, 2'd1, 1'b0};
        tbl[19] = '{1'b0, 2'd0, 1'b1, 17'd3,     1'b1, 17'd76799, 1'b1, 17'd76799, 2'd1, 1'b0, 2'd1, 1'b1};

        reset    = 1'b0;
        mode_req = 1'b0;
        mode_sel = 2'd0;
        src_we   = '0;
        src_addr = '0;
        src_data = '0;

        // T1: reset held with sources writing
        drive(0, 1'b1, 17'd5, 16'h1234);
        drive(1, 1'b1, 17'd6, 16'h5678);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t1_we_rst", 32'(we_out), 32'd0);
            chk("t1_act_rst", 32'(active_mode), 32'd0);
            chk("t1_pend_rst", 32'(switch_pending), 32'd0);
            chk("t1_addr_rst", 32'(wAddr_out), 32'd0);
        end
        reset = 1'b1;
        tick();
        chk("t1_first_we", 32'(we_out), 32'd1);
        chk("t1_first_addr", 32'(wAddr_out), 32'd5);
        chk("t1_first_data", 32'(wData_out), 32'h1234);

        // T2: full-frame passthrough from src0, src1 writing other data
        errs   = 0;
        fd_cnt = 0;
        fd_at  = -1;
        for (int i = 0; i < 76800; i++) begin
            drive(0, 1'b1, 17'(i), 16'(i));
            drive(1, 1'b1, 17'(i), ~16'(i));
            tick();
            if (we_out !== 1'b1 || wAddr_out !== 17'(i) || wData_out !== 16'(i)) errs++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_at = i;
            end
        end
        drive(0, 1'b0, 17'd0, 16'd0);
        drive(1, 1'b0, 17'd0, 16'd0);
        tick();
        if (frame_done === 1'b1) fd_cnt++;
        chk("t2_stream_errs", 32'(errs), 32'd0);
        chk("t2_fd_count", 32'(fd_cnt), 32'd1);
        chk("t2_fd_at", 32'(fd_at), 32'd76799);
        chk("t2_we_idle", 32'(we_out), 32'd0);

        // T6, T3, T4 vectors
        for (int k = 0; k < 20; k++) begin
            mode_req = tbl[k].req;
            mode_sel = tbl[k].sel;
            drive(0, tbl[k].we0, tbl[k].a0, tdat(2'd0, tbl[k].a0));
            drive(1, tbl[k].we1, tbl[k].a1, tdat(2'd1, tbl[k].a1));
            tick();
            chk($sformatf("v%0d_we", k), 32'(we_out), 32'(tbl[k].ewe));
            chk($sformatf("v%0d_addr", k), 32'(wAddr_out), 32'(tbl[k].eaddr));
            chk($sformatf("v%0d_data", k), 32'(wData_out), 32'(tdat(tbl[k].esrc, tbl[k].eaddr)));
            chk($sformatf("v%0d_pend", k), 32'(switch_pending), 32'(tbl[k].epend));
            chk($sformatf("v%0d_act", k), 32'(active_mode), 32'(tbl[k].eact));
            chk($sformatf("v%0d_fd", k), 32'(frame_done), 32'(tbl[k].efd));
        end
        mode_req = 1'b0;

        // T5: timeout switch to idle src2 (active is src1 here)
        drive(0, 1'b0, 17'd0, 16'd0);
        drive(1, 1'b1, 17'd7, 16'h0777);
        drive(2, 1'b0, 17'd0, 16'd0);
        mode_req = 1'b1;
        mode_sel = 2'd2;
        tick();
        mode_req = 1'b0;
        chk("t5_pend_start", 32'(switch_pending), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("t5_to_c%0d", k), 32'(switch_timeout), (k == 16) ? 32'd1 : 32'd0);
            chk($sformatf("t5_pend_c%0d", k), 32'(switch_pending), (k == 16) ? 32'd0 : 32'd1);
            chk($sformatf("t5_we_c%0d", k), 32'(we_out), 32'd1);
        end
        chk("t5_act", 32'(active_mode), 32'd2);
        tick();
        chk("t5_to_clear", 32'(switch_timeout), 32'd0);
        chk("t5_we_idle", 32'(we_out), 32'd0);
        chk("t5_addr_hold", 32'(wAddr_out), 32'd7);

        // Mid-switch reset discards the pending target
        mode_req = 1'b1;
        mode_sel = 2'd0;
        tick();
        mode_req = 1'b0;
        chk("rs_pend", 32'(switch_pending), 32'd1);
        reset = 1'b0;
        tick();
        chk("rs_pend_clr", 32'(switch_pending), 32'd0);
        chk("rs_act_def", 32'(active_mode), 32'd0);
        chk("rs_we", 32'(we_out), 32'd0);
        reset = 1'b1;
        drive(1, 1'b0, 17'd0, 16'd0);
        drive(2, 1'b1, 17'd0, 16'h0222);
        tick();
        chk("rs_no_commit", 32'(active_mode), 32'd0);
        chk("rs_no_fwd", 32'(we_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
